// File: rtl/cdc_handshake_tx.sv
// ============================================================================
//  Module   : cdc_handshake_tx
//  Purpose  : Source side of a 4-phase req/ack clock-domain-crossing handshake.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module cdc_handshake_tx #(
    parameter int WIDTH       = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             send_valid,
    input  logic [WIDTH-1:0] send_data,
    output logic             send_ready,
    output logic             done,
    output logic             req,
    output logic [WIDTH-1:0] data_out,
    input  logic             ack
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        REL  = 2'd2
    } state_t;

    state_t                 state_q, state_d;
    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   req_q, req_d;
    logic                   done_q, done_d;
    logic [WIDTH-1:0]       data_q, data_d;
    logic                   ack_s;
    logic                   accept;

    // Raw ack only ever feeds the first synchronizer flop.
    assign ack_s      = sync_q[SYNC_STAGES-1];
    assign send_ready = (state_q == IDLE) && !ack_s;
    assign accept     = send_valid && send_ready;

    always_comb begin
        sync_d  = {sync_q[SYNC_STAGES-2:0], ack};
        state_d = state_q;
        req_d   = req_q;
        done_d  = 1'b0;
        data_d  = data_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    data_d  = send_data;
                    req_d   = 1'b1;
                    state_d = REQ;
                end
            end
            REQ: begin
                if (ack_s) begin
                    req_d   = 1'b0;
                    state_d = REL;
                end
            end
            REL: begin
                // Return-to-zero seen: the far side has released the word.
                if (!ack_s) begin
                    done_d  = 1'b1;
                    state_d = IDLE;
                end
            end
            default: begin
                req_d   = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            sync_q  <= '0;
            req_q   <= 1'b0;
            done_q  <= 1'b0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            sync_q  <= sync_d;
            req_q   <= req_d;
            done_q  <= done_d;
            data_q  <= data_d;
        end
    end

    assign req      = req_q;
    assign done     = done_q;
    assign data_out = data_q;

endmodule

`default_nettype wire

// File: tb/tb_cdc_handshake_tx.sv
// ============================================================================
//  Module   : tb_cdc_handshake_tx
//  Purpose  : Scoreboard bench for cdc_handshake_tx with a far-side responder.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_cdc_handshake_tx;

    localparam int WIDTH = 4;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             send_valid = 1'b0;
    logic [WIDTH-1:0] send_data = '0;
    logic             send_ready;
    logic             done;
    logic             req;
    logic [WIDTH-1:0] data_out;
    logic             ack;

    logic             resp_en   = 1'b1;
    logic             ack_force = 1'b0;

    int total = 0;
    int bad   = 0;
    int viol  = 0;

    logic [WIDTH-1:0] exp_q[$];

    cdc_handshake_tx #(.WIDTH(WIDTH), .SYNC_STAGES(2)) dut (
        .clk        (clk),
        .rst        (rst),
        .send_valid (send_valid),
        .send_data  (send_data),
        .send_ready (send_ready),
        .done       (done),
        .req        (req),
        .data_out   (data_out),
        .ack        (ack)
    );

    always #5 clk = ~clk;

    // Far side: follows req one cycle late when enabled, otherwise held by the test.
    initial begin
        ack = 1'b0;
        forever begin
            @(posedge clk);
            #2;
            ack = resp_en ? req : ack_force;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Scoreboard monitor plus data_out stability invariant.
    logic [WIDTH-1:0] prev_data = '0;
    logic             prev_hold = 1'b0;
    logic             prev_rst  = 1'b1;
    initial begin
        forever begin
            @(negedge clk);
            if (done === 1'b1) begin
                if (exp_q.size() == 0) begin
                    chk("done_unexpected", 32'(done), 32'd0);
                end else begin
                    chk("done_data", 32'(data_out), 32'(exp_q.pop_front()));
                end
            end
            if (!rst && !prev_rst && prev_hold && (data_out !== prev_data))
                viol++;
            prev_data = data_out;
            prev_hold = req | dut.ack_s;
            prev_rst  = rst;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_done(input string name);
        bit seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            step();
            if (done) begin
                seen = 1'b1;
                break;
            end
        end
        chk(name, 32'(seen), 32'd1);
    endtask

    logic r_ready, r_done, acc_in_done, accepted;

    initial begin
        // Reset values
        #1 rst = 1'b1;
        #2;
        chk("rst_req",   32'(req),        32'd0);
        chk("rst_data",  32'(data_out),   32'd0);
        chk("rst_done",  32'(done),       32'd0);
        chk("rst_ready", 32'(send_ready), 32'd1);
        step();
        step();
        rst = 1'b0;
        step();
        step();
        chk("idle_req",   32'(req),        32'd0);
        chk("idle_data",  32'(data_out),   32'd0);
        chk("idle_done",  32'(done),       32'd0);
        chk("idle_ready", 32'(send_ready), 32'd1);

        // Single transfer with ignored inputs while in REQ
        send_data  = 4'b1010;
        send_valid = 1'b1;
        exp_q.push_back(4'b1010);
        step();                                   // edge k
        send_valid = 1'b0;
        chk("k_req",   32'(req),        32'd1);
        chk("k_data",  32'(data_out),   32'b1010);
        chk("k_ready", 32'(send_ready), 32'd0);
        send_data  = 4'b0101;
        send_valid = 1'b1;
        step();                                   // k+1: ack first sampled high
        chk("k1_req", 32'(req), 32'd1);
        step();                                   // k+2
        send_valid = 1'b0;
        chk("ign_data",  32'(data_out),   32'b1010);
        chk("ign_ready", 32'(send_ready), 32'd0);
        chk("k2_req",    32'(req),        32'd1);
        step();                                   // k+3
        chk("k3_req_fall", 32'(req),      32'd0);
        chk("k3_data",     32'(data_out), 32'b1010);
        step();                                   // k+4: ack first sampled low
        chk("k4_done", 32'(done), 32'd0);
        step();
        chk("k5_done", 32'(done), 32'd0);
        step();                                   // k+6
        chk("k6_done",  32'(done),       32'd1);
        chk("k6_ready", 32'(send_ready), 32'd1);
        step();
        chk("k7_done", 32'(done), 32'd0);

        // Back-to-back with send_valid held
        send_data  = 4'b1010;
        send_valid = 1'b1;
        exp_q.push_back(4'b1010);
        accepted = 1'b0;
        for (int i = 0; i < 40; i++) begin
            r_ready = send_ready;
            step();
            if (r_ready) begin
                accepted = 1'b1;
                break;
            end
        end
        chk("b2b_first_acc", 32'(accepted), 32'd1);
        send_data = 4'b1111;
        exp_q.push_back(4'b1111);
        accepted    = 1'b0;
        acc_in_done = 1'b0;
        for (int i = 0; i < 40; i++) begin
            r_ready = send_ready;
            r_done  = done;
            step();
            if (r_ready) begin
                accepted    = 1'b1;
                acc_in_done = r_done;
                break;
            end
        end
        send_valid = 1'b0;
        chk("b2b_second_acc", 32'(accepted),    32'd1);
        chk("b2b_in_done",    32'(acc_in_done), 32'd1);
        chk("b2b_data",       32'(data_out),    32'b1111);
        wait_done("b2b_done_timeout");
        step();
        step();

        // Stale ack held across reset
        resp_en   = 1'b0;
        ack_force = 1'b1;
        step();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        step();
        step();
        step();
        chk("stale_ready", 32'(send_ready), 32'd0);
        send_data  = 4'b0011;
        send_valid = 1'b1;
        exp_q.push_back(4'b0011);
        step();
        step();
        chk("stale_no_req",   32'(req),        32'd0);
        chk("stale_ready2",   32'(send_ready), 32'd0);
        ack_force = 1'b0;
        step();                                   // n: ack first sampled low
        chk("stale_n_ready", 32'(send_ready), 32'd0);
        chk("stale_n_req",   32'(req),        32'd0);
        step();                                   // n+1
        chk("stale_n1_ready", 32'(send_ready), 32'd1);
        chk("stale_n1_req",   32'(req),        32'd0);
        step();                                   // n+2: accepted
        send_valid = 1'b0;
        resp_en    = 1'b1;
        chk("stale_n2_req",  32'(req),      32'd1);
        chk("stale_n2_data", 32'(data_out), 32'b0011);
        wait_done("stale_done_timeout");
        step();
        step();

        // Reset in REQ with ack high
        send_data  = 4'b0110;
        send_valid = 1'b1;
        step();
        send_valid = 1'b0;
        step();
        resp_en   = 1'b0;
        ack_force = 1'b1;
        chk("mid_pre_req", 32'(req), 32'd1);
        chk("mid_pre_ack", 32'(ack), 32'd1);
        rst = 1'b1;
        #1;
        chk("mid_req",   32'(req),        32'd0);
        chk("mid_data",  32'(data_out),   32'd0);
        chk("mid_done",  32'(done),       32'd0);
        chk("mid_ready", 32'(send_ready), 32'd1);
        step();
        step();
        rst       = 1'b0;
        ack_force = 1'b0;
        step();
        step();
        step();
        chk("post_mid_done", 32'(done), 32'd0);
        resp_en    = 1'b1;
        send_data  = 4'b1111;
        send_valid = 1'b1;
        exp_q.push_back(4'b1111);
        step();
        send_valid = 1'b0;
        chk("fresh_req",  32'(req),      32'd1);
        chk("fresh_data", 32'(data_out), 32'b1111);
        wait_done("fresh_done_timeout");
        step();
        step();

        chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        chk("data_stable",      32'(viol),         32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
